// File: rtl/sound_glu_pkg.sv
// Shared definitions for the IIgs sound GLU: host register map, control bits, FSM states.
package sound_pkg;

  localparam logic [1:0] GLU_CTRL = 2'd0;
  localparam logic [1:0] GLU_DATA = 2'd1;
  localparam logic [1:0] GLU_ALO  = 2'd2;
  localparam logic [1:0] GLU_AHI  = 2'd3;

  localparam int unsigned CTL_BUSY = 7;
  localparam int unsigned CTL_RAM  = 6;
  localparam int unsigned CTL_AINC = 5;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSlot,
    StRamCap,
    StDocStrobe,
    StDocCap
  } glu_state_e;

endpackage

// File: rtl/sound_glu_if.sv
// Host-side register bus of the sound GLU ($C03C-$C03F).
interface sound_glu_if;

  logic       host_sel;
  logic       host_wr;
  logic [1:0] host_addr;
  logic [7:0] host_din;
  logic [7:0] host_dout;

  modport master (
    output host_sel,
    output host_wr,
    output host_addr,
    output host_din,
    input  host_dout
  );

  modport slave (
    input  host_sel,
    input  host_wr,
    input  host_addr,
    input  host_din,
    output host_dout
  );

endinterface

// File: rtl/sound_ram_arb.sv
// Sound RAM arbiter: the DOC owns every slot it strobes; the host gets free 7M slots.
module sound_ram_arb #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_7m_en_i,
  input  logic              doc_osc_en_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [7:0]        host_wdata_i,
  input  logic [ADDR_W-1:0] doc_addr_i,
  output logic              grant_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o
);

  always_comb begin
    grant_o     = host_req_i && clk_7m_en_i && !doc_osc_en_i;
    ram_addr_o  = grant_o ? host_addr_i : doc_addr_i;
    ram_we_o    = grant_o && host_we_i;
    ram_wdata_o = host_wdata_i;
  end

endmodule

// File: rtl/sound_glu.sv
// Apple IIgs sound GLU: host registers, DOC register access and shared sound RAM access.
module sound_glu #(
  parameter int unsigned ADDR_W           = 16,
  parameter bit          AUTO_INC_DEFAULT = 1'b0
) (
  input  logic              CLK_14M,
  input  logic              reset_n,
  input  logic              clk_7M_en,
  sound_glu_if.slave        host,
  input  logic              doc_osc_en,
  input  logic [ADDR_W-1:0] doc_addr,
  input  logic [7:0]        doc_rdata,
  output logic [7:0]        doc_reg_addr,
  output logic [7:0]        doc_reg_wdata,
  output logic              doc_wr,
  output logic              doc_host_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [3:0]        volume,
  output logic              busy
);

  import sound_pkg::*;

  glu_state_e        state_q, state_d;
  logic              ctrl_ram_q, ctrl_ram_d;
  logic              ctrl_ainc_q, ctrl_ainc_d;
  logic [3:0]        volume_q, volume_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        data_latch_q, data_latch_d;
  logic [7:0]        host_dout_q, host_dout_d;
  logic              is_wr_q, is_wr_d;
  logic [7:0]        ctrl_rd;

  logic data_sel, start, grant, host_req;
  logic access_done, cap_ram, cap_doc;

  assign busy     = (state_q != StIdle);
  assign data_sel = host.host_sel && (host.host_addr == GLU_DATA);
  // Data accesses seen while busy (including the completion cycle) launch nothing.
  assign start    = data_sel && !busy;
  assign host_req = (state_q == StWaitSlot);

  sound_ram_arb #(
    .ADDR_W(ADDR_W)
  ) u_ram_arb (
    .clk_7m_en_i (clk_7M_en),
    .doc_osc_en_i(doc_osc_en),
    .host_req_i  (host_req),
    .host_we_i   (is_wr_q),
    .host_addr_i (addr_q),
    .host_wdata_i(wdata_q),
    .doc_addr_i  (doc_addr),
    .grant_o     (grant),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata)
  );

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start) state_d = ctrl_ram_q ? StWaitSlot : StDocStrobe;
      StWaitSlot:  if (grant) state_d = is_wr_q ? StIdle : StRamCap;
      StRamCap:    state_d = StIdle;
      StDocStrobe: state_d = is_wr_q ? StIdle : StDocCap;
      StDocCap:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // A single DOC strobe per access keeps the OIR irq stack from popping twice.
  always_comb begin
    doc_host_en = 1'b0;
    doc_wr      = 1'b0;
    access_done = 1'b0;
    cap_ram     = 1'b0;
    cap_doc     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StWaitSlot:  access_done = grant && is_wr_q;
      StRamCap: begin
        cap_ram     = 1'b1;
        access_done = 1'b1;
      end
      StDocStrobe: begin
        doc_host_en = 1'b1;
        doc_wr      = is_wr_q;
        access_done = is_wr_q;
      end
      StDocCap: begin
        cap_doc     = 1'b1;
        access_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ctrl_rd           = 8'h00;
    ctrl_rd[CTL_BUSY] = busy;
    ctrl_rd[CTL_RAM]  = ctrl_ram_q;
    ctrl_rd[CTL_AINC] = ctrl_ainc_q;
    ctrl_rd[3:0]      = volume_q;
  end

  always_comb begin
    ctrl_ram_d   = ctrl_ram_q;
    ctrl_ainc_d  = ctrl_ainc_q;
    volume_d     = volume_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_latch_d = data_latch_q;
    host_dout_d  = host_dout_q;
    is_wr_d      = is_wr_q;

    if (host.host_sel && host.host_wr) begin
      case (host.host_addr)
        GLU_CTRL: begin
          ctrl_ram_d  = host.host_din[CTL_RAM];
          ctrl_ainc_d = host.host_din[CTL_AINC];
          volume_d    = host.host_din[3:0];
        end
        GLU_DATA: if (!busy) wdata_d = host.host_din;
        GLU_ALO:  if (!busy) addr_d[7:0] = host.host_din;
        GLU_AHI:  if (!busy) addr_d[ADDR_W-1:8] = (ADDR_W-8)'(host.host_din);
        default: ;
      endcase
    end

    // Data reads return the previous result; the new one lands in data_latch later.
    if (host.host_sel && !host.host_wr) begin
      case (host.host_addr)
        GLU_CTRL: host_dout_d = ctrl_rd;
        GLU_DATA: host_dout_d = data_latch_q;
        GLU_ALO:  host_dout_d = addr_q[7:0];
        GLU_AHI:  host_dout_d = 8'(addr_q >> 8);
        default:  host_dout_d = host_dout_q;
      endcase
    end

    if (start) is_wr_d = host.host_wr;
    if (cap_ram) data_latch_d = ram_rdata;
    if (cap_doc) data_latch_d = doc_rdata;
    if (access_done && ctrl_ainc_q) addr_d = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_ram_q   <= 1'b0;
      ctrl_ainc_q  <= AUTO_INC_DEFAULT;
      volume_q     <= 4'h0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      data_latch_q <= 8'h00;
      host_dout_q  <= 8'h00;
      is_wr_q      <= 1'b0;
    end else begin
      ctrl_ram_q   <= ctrl_ram_d;
      ctrl_ainc_q  <= ctrl_ainc_d;
      volume_q     <= volume_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_latch_q <= data_latch_d;
      host_dout_q  <= host_dout_d;
      is_wr_q      <= is_wr_d;
    end
  end

  assign host.host_dout = host_dout_q;
  assign volume         = volume_q;
  assign doc_reg_addr   = addr_q[7:0];
  assign doc_reg_wdata  = wdata_q;

endmodule

// File: tb/tb_sound_glu.sv
// Directed bench for sound_glu with a behavioural sound RAM and DOC register file.
module tb_sound_glu;

  logic        CLK_14M   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        clk_7M_en = 1'b0;
  logic        osc_force = 1'b0;
  logic        osc_phase = 1'b0;
  logic [2:0]  phase     = 3'd0;
  logic        doc_osc_en;
  logic [15:0] doc_addr  = 16'hBEEF;
  logic [7:0]  doc_rdata = 8'h00;
  logic [7:0]  ram_rdata = 8'h00;

  logic [7:0]  doc_reg_addr, doc_reg_wdata, ram_wdata;
  logic        doc_wr, doc_host_en, ram_we, busy;
  logic [15:0] ram_addr;
  logic [3:0]  volume;

  logic [7:0]  mem [0:65535];
  logic [7:0]  doc_regs [0:255];

  int vectors = 0, miscompares = 0;
  int we_cnt = 0, collide_cnt = 0, addr_err_cnt = 0, strobe_cnt = 0;
  logic [15:0] last_we_addr  = 16'h0;
  logic [7:0]  last_we_data  = 8'h0;
  logic [7:0]  last_doc_addr = 8'h0, last_doc_wdata = 8'h0;
  logic        last_doc_wr   = 1'b0;
  logic [7:0]  rd;
  int          we_base, st_base;

  sound_glu_if host_bus ();

  sound_glu #(
    .ADDR_W          (16),
    .AUTO_INC_DEFAULT(1'b0)
  ) dut (
    .CLK_14M      (CLK_14M),
    .reset_n      (reset_n),
    .clk_7M_en    (clk_7M_en),
    .host         (host_bus),
    .doc_osc_en   (doc_osc_en),
    .doc_addr     (doc_addr),
    .doc_rdata    (doc_rdata),
    .doc_reg_addr (doc_reg_addr),
    .doc_reg_wdata(doc_reg_wdata),
    .doc_wr       (doc_wr),
    .doc_host_en  (doc_host_en),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .volume       (volume),
    .busy         (busy)
  );

  always #5 CLK_14M = ~CLK_14M;

  assign doc_osc_en = clk_7M_en & (osc_force | (osc_phase & (phase == 3'd7)));

  // Environment: 7M enable, synchronous RAM, DOC register file, and bus monitors.
  always @(posedge CLK_14M) begin
    clk_7M_en <= ~clk_7M_en;
    if (clk_7M_en) phase <= phase + 3'd1;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (doc_host_en && doc_wr) doc_regs[doc_reg_addr] <= doc_reg_wdata;
    doc_rdata <= doc_regs[doc_reg_addr];
    if (ram_we) begin
      we_cnt++;
      last_we_addr = ram_addr;
      last_we_data = ram_wdata;
    end
    if (ram_we && doc_osc_en) collide_cnt++;
    if (doc_osc_en && (ram_addr !== doc_addr)) addr_err_cnt++;
    if (doc_host_en) begin
      strobe_cnt++;
      last_doc_wr    = doc_wr;
      last_doc_addr  = doc_reg_addr;
      last_doc_wdata = doc_reg_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; holds the strobe for one cycle; returns host_dout after it.
  task automatic host_op(input logic wr, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    host_bus.host_sel  = 1'b1;
    host_bus.host_wr   = wr;
    host_bus.host_addr = a;
    host_bus.host_din  = d;
    @(negedge CLK_14M);
    host_bus.host_sel  = 1'b0;
    q = host_bus.host_dout;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge CLK_14M);
      n++;
    end
    check(tag, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) doc_regs[i] = 8'h00;
    mem[16'h1235]   = 8'h3C;
    doc_regs[8'hE0] = 8'h87;
    host_bus.host_sel  = 1'b0;
    host_bus.host_wr   = 1'b0;
    host_bus.host_addr = 2'd0;
    host_bus.host_din  = 8'h00;

    repeat (3) @(negedge CLK_14M);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dout", 32'(host_bus.host_dout), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_doc_en", 32'(doc_host_en), 32'h0);
    check("rst_volume", 32'(volume), 32'h0);
    reset_n = 1'b1;
    @(negedge CLK_14M);
    host_op(1'b0, 2'd0, 8'h00, rd);
    check("ctrl_reset_read", 32'(rd), 32'h00);

    // Control: bit 7 and bit 4 read back as 0 when idle.
    host_op(1'b1, 2'd0, 8'h7A, rd);
    host_op(1'b0, 2'd0, 8'h00, rd);
    check("ctrl_mask_read", 32'(rd), 32'h6A);
    check("volume_out", 32'(volume), 32'hA);

    // RAM write with auto-increment at 1234.
    osc_phase = 1'b1;
    host_op(1'b1, 2'd0, 8'h60, rd);
    host_op(1'b1, 2'd2, 8'h34, rd);
    host_op(1'b1, 2'd3, 8'h12, rd);
    host_op(1'b0, 2'd2, 8'h00, rd);
    check("alo_read", 32'(rd), 32'h34);
    host_op(1'b0, 2'd3, 8'h00, rd);
    check("ahi_read", 32'(rd), 32'h12);
    we_base = we_cnt;
    host_op(1'b1, 2'd1, 8'hA5, rd);
    wait_idle("wr_idle");
    check("wr_pulses", 32'(we_cnt - we_base), 32'd1);
    check("wr_addr", 32'(last_we_addr), 32'h1234);
    check("wr_data", 32'(last_we_data), 32'hA5);
    host_op(1'b0, 2'd2, 8'h00, rd);
    check("wr_ainc", 32'(rd), 32'h35);

    // Dummy read: first returns the stale latch, second the fetched byte.
    host_op(1'b0, 2'd1, 8'h00, rd);
    check("rd1_stale", 32'(rd), 32'h00);
    wait_idle("rd1_idle");
    host_op(1'b0, 2'd1, 8'h00, rd);
    check("rd2_data", 32'(rd), 32'h3C);
    wait_idle("rd2_idle");
    host_op(1'b0, 2'd2, 8'h00, rd);
    check("rd_ainc_lo", 32'(rd), 32'h37);
    host_op(1'b0, 2'd3, 8'h00, rd);
    check("rd_ainc_hi", 32'(rd), 32'h12);

    // DOC OIR read: one strobe, doc_wr low, result on the next read.
    host_op(1'b1, 2'd0, 8'h00, rd);
    host_op(1'b1, 2'd2, 8'hE0, rd);
    st_base = strobe_cnt;
    host_op(1'b0, 2'd1, 8'h00, rd);
    check("doc_rd_stale", 32'(rd), 32'h00);
    wait_idle("doc_rd_idle");
    check("doc_rd_strobes", 32'(strobe_cnt - st_base), 32'd1);
    check("doc_rd_wr", 32'(last_doc_wr), 32'h0);
    check("doc_rd_addr", 32'(last_doc_addr), 32'hE0);
    host_op(1'b0, 2'd1, 8'h00, rd);
    check("doc_rd_data", 32'(rd), 32'h87);
    wait_idle("doc_rd2_idle");
    host_op(1'b0, 2'd2, 8'h00, rd);
    check("doc_no_ainc", 32'(rd), 32'hE0);

    // DOC register write.
    host_op(1'b1, 2'd2, 8'h41, rd);
    st_base = strobe_cnt;
    host_op(1'b1, 2'd1, 8'h5F, rd);
    wait_idle("doc_wr_idle");
    check("doc_wr_strobes", 32'(strobe_cnt - st_base), 32'd1);
    check("doc_wr_flag", 32'(last_doc_wr), 32'h1);
    check("doc_wr_addr", 32'(last_doc_addr), 32'h41);
    check("doc_wr_data", 32'(last_doc_wdata), 32'h5F);

    // Collision: DOC claims every 7M slot, the host must wait.
    host_op(1'b1, 2'd0, 8'h40, rd);
    host_op(1'b1, 2'd2, 8'h00, rd);
    host_op(1'b1, 2'd3, 8'h20, rd);
    osc_force = 1'b1;
    doc_addr  = 16'h8421;
    we_base   = we_cnt;
    host_op(1'b1, 2'd1, 8'h77, rd);
    repeat (10) @(negedge CLK_14M);
    check("coll_busy", 32'(busy), 32'h1);
    check("coll_no_we", 32'(we_cnt - we_base), 32'd0);
    host_op(1'b0, 2'd0, 8'h00, rd);
    check("coll_ctrl_busy", 32'(rd), 32'hC0);
    osc_force = 1'b0;
    wait_idle("coll_idle");
    check("coll_pulses", 32'(we_cnt - we_base), 32'd1);
    check("coll_addr", 32'(last_we_addr), 32'h2000);
    check("coll_mem", 32'(mem[16'h2000]), 32'h77);
    check("coll_overlap", 32'(collide_cnt), 32'd0);
    check("coll_ram_addr", 32'(addr_err_cnt), 32'd0);

    // Busy drop and address wrap.
    host_op(1'b1, 2'd0, 8'h60, rd);
    host_op(1'b1, 2'd2, 8'hFF, rd);
    host_op(1'b1, 2'd3, 8'hFF, rd);
    we_base = we_cnt;
    host_op(1'b1, 2'd1, 8'h11, rd);
    host_op(1'b1, 2'd1, 8'h22, rd);
    wait_idle("wrap_idle");
    check("wrap_pulses", 32'(we_cnt - we_base), 32'd1);
    check("wrap_addr", 32'(last_we_addr), 32'hFFFF);
    check("wrap_data", 32'(last_we_data), 32'h11);
    host_op(1'b0, 2'd2, 8'h00, rd);
    check("wrap_lo", 32'(rd), 32'h00);
    host_op(1'b0, 2'd3, 8'h00, rd);
    check("wrap_hi", 32'(rd), 32'h00);

    // Async reset while parked in WAIT_SLOT.
    host_op(1'b1, 2'd0, 8'h4F, rd);
    host_op(1'b1, 2'd2, 8'h00, rd);
    host_op(1'b1, 2'd3, 8'h30, rd);
    osc_force = 1'b1;
    we_base   = we_cnt;
    host_op(1'b1, 2'd1, 8'h99, rd);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_ram_we", 32'(ram_we), 32'h0);
    check("arst_dout", 32'(host_bus.host_dout), 32'h0);
    check("arst_volume", 32'(volume), 32'h0);
    check("arst_doc_en", 32'(doc_host_en), 32'h0);
    check("arst_doc_wr", 32'(doc_wr), 32'h0);
    osc_force = 1'b0;
    repeat (6) @(negedge CLK_14M);
    reset_n = 1'b1;
    repeat (6) @(negedge CLK_14M);
    check("arst_no_we", 32'(we_cnt - we_base), 32'd0);
    check("arst_mem", 32'(mem[16'h3000]), 32'h00);
    host_op(1'b0, 2'd0, 8'h00, rd);
    check("arst_ctrl", 32'(rd), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sound_glu.md
Name: sound_glu

Overview:
- Host-side sound interface for the Apple IIgs sound subsystem.
- Exposes the four host registers at $C03C-$C03F: control, data, address low and address high.
- Each data-register access is converted into either an ES5503 DOC register access or a sound-RAM access.
- Arbitrates the single 64 KB sound RAM between DOC oscillator fetches and host accesses; the DOC always has priority.

Parameters:
- ADDR_W, 16, sound RAM / pointer address width.
- AUTO_INC_DEFAULT, 0, reset value of control bit 5.

Ports:
- CLK_14M  in  1  system clock, 14.318 MHz
- reset_n  in  1  asynchronous, active-low reset
- clk_7M_en  in  1  7M clock enable, shared with the DOC
- host_sel  in  1  one-cycle strobe; host access to $C03C-$C03F
- host_wr  in  1  1 = write, 0 = read; qualified by host_sel
- host_addr  in  2  0 = control, 1 = data, 2 = addr low, 3 = addr high
- host_din  in  8  host write data
- host_dout  out  8  host read data; registered, valid the cycle after host_sel
- doc_osc_en  in  1  DOC RAM slot strobe; doc_addr is presented to RAM in this cycle
- doc_addr  in  16  DOC sample-fetch address
- doc_rdata  in  8  DOC register read data; one-cycle latency
- doc_reg_addr  out  8  DOC register address
- doc_reg_wdata  out  8  DOC register write data
- doc_wr  out  1  DOC write qualifier
- doc_host_en  out  1  DOC access strobe; one cycle per access
- ram_addr  out  16  sound RAM address (combinational mux)
- ram_we  out  1  sound RAM write enable
- ram_wdata  out  8  sound RAM write data
- ram_rdata  in  8  synchronous RAM read data; one-cycle latency
- volume  out  4  control[3:0], to the output mixer
- busy  out  1  access in flight (= control bit 7)

Behaviour:
- Reset (async, reset_n=0) clears: ctrl = {1'b0, 1'b0, AUTO_INC_DEFAULT, 1'b0, 4'h0}, addr = 0, data_latch = 0, state = IDLE, host_dout = 0, doc_host_en = 0, doc_wr = 0, ram_we = 0, busy = 0. Any in-flight access is dropped; no partial strobe is emitted.
- Control register:
  - bit 7 busy (read-only).
  - bit 6 target: 1 = RAM, 0 = DOC.
  - bit 5 auto-increment.
  - bit 4 reserved, reads 0.
  - bits 3:0 volume.
  - Control writes are always accepted, even while busy.
- Address registers:
  - Read/write at any time; writes are dropped while busy.
  - addr = {addr_hi, addr_lo}.
  - DOC accesses use addr_lo as doc_reg_addr.
- Data write (busy=0): latch host_din into wdata and start an access:
  - target RAM -> WAIT_SLOT.
  - target DOC -> DOC_STROBE.
- Data read (busy=0):
  - host_dout <= data_latch, i.e. the previous result (IIgs dummy-read semantics).
  - Starts a read access at the current addr.
- Data-register access while busy:
  - Write dropped; read returns data_latch and launches nothing.
  - Applies also to the completion cycle.
- FSM states: IDLE, WAIT_SLOT, RAM_CAP, DOC_STROBE, DOC_CAP.
- WAIT_SLOT:
  - Host grant occurs on a cycle with clk_7M_en=1 and doc_osc_en=0.
  - On grant, ram_addr = addr, and ram_we = 1 with ram_wdata = wdata for a write.
  - Write -> IDLE; read -> RAM_CAP.
  - In all non-grant cycles, ram_addr = doc_addr and ram_we = 0.
- RAM_CAP: data_latch <= ram_rdata -> IDLE.
- DOC_STROBE: exactly one cycle with doc_host_en=1, doc_wr = write, doc_reg_wdata = wdata.
  - Write -> IDLE; read -> DOC_CAP.
  - The single strobe prevents a double pop of the DOC OIR irq stack.
- DOC_CAP: data_latch <= doc_rdata -> IDLE.
- Auto-increment: when an access completes with ctrl[5]=1, addr <= addr + 1, 16-bit wrap FFFF -> 0000.
- Latency: DOC access 1-2 cycles; RAM write ≥1 cycle; RAM read ≥2 cycles. Worst-case RAM wait is bounded by 2 clk_7M_en periods.
- host_dout per register:
  - Control read: {busy, ctrl[6:5], 1'b0, ctrl[3:0]}.
  - Address reads return the live registers.

Decomposition:
- Shared package sound_pkg holds:
  - host register offsets (GLU_CTRL=0, GLU_DATA=1, GLU_ALO=2, GLU_AHI=3);
  - control bit indices (CTL_BUSY=7, CTL_RAM=6, CTL_AINC=5);
  - the FSM state enum.
- One sub-module is natural: sound_ram_arb, the grant logic plus the ram_addr/ram_we mux, reusable if further RAM requesters are added.

Test Plan:
- RAM write with auto-inc: ctrl=8'h60, addr=16'h1234, write data 8'hA5 -> exactly one ram_we pulse at 1234 with data A5, not in a doc_osc_en cycle; addr becomes 1235.
- RAM dummy read: preload RAM[1235]=8'h3C; read data twice -> first read returns the old latch, second returns 3C; addr ends at 1237.
- DOC OIR read: ctrl=8'h00, addr_lo=8'hE0, read data -> exactly one doc_host_en cycle with doc_wr=0; next read returns the captured doc_rdata.
- Collision: host RAM request pending while doc_osc_en fires every 7M cycle phase 7 -> grant never coincides with doc_osc_en; ram_addr equals doc_addr on those cycles.
- Busy drop and wrap: addr=16'hFFFF with auto-inc, write data, then immediately write data again while busy -> second write dropped; addr=0000.
- Async reset mid-WAIT_SLOT: deassert reset_n between clock edges -> all outputs zero immediately; no ram_we pulse; busy=0.
